spi_config_sram_bridge: RTL and testbench

Clock-domain-side consumer of the SPI barrier outputs: turns the one-cycle `write_new` pulse and the level `read_sync` signal into single-port SRAM write and read transactions, then returns read data for the MISO shift register. Sits between the SPI barrier crossing and the configuration SRAM. Runs entirely in the `clk` domain. Serialises overlapping requests through a small FSM with one-deep pending slots and a sticky overrun flag.

---
 rtl/spi_config_pkg.sv | 29 ++
 rtl/rising_edge_detector.sv | 25 ++
 rtl/spi_config_sram_bridge.sv | 140 ++++++++++++++
 tb/tb_spi_config_sram_bridge.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_config_pkg.sv
// Shared types and constants for the SPI configuration SRAM bridge.
// Holds the FSM state encoding and the legal read-latency range.
package spi_config_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      READ      = 2'd2,
      READ_WAIT = 2'd3
   } state_e;

   localparam int unsigned READ_LATENCY_MIN = 32'd1;
   localparam int unsigned READ_LATENCY_MAX = 32'd4;
   localparam int unsigned LAT_CNT_WIDTH    = 32'd2;

   // Out-of-range latencies are clamped so the countdown never wraps.
   function automatic logic [LAT_CNT_WIDTH-1:0] latency_load(input int unsigned latency);
      int unsigned clamped;
      if (latency < READ_LATENCY_MIN) begin
         clamped = READ_LATENCY_MIN;
      end else if (latency > READ_LATENCY_MAX) begin
         clamped = READ_LATENCY_MAX;
      end else begin
         clamped = latency;
      end
      return LAT_CNT_WIDTH'(clamped - 32'd1);
   endfunction

endpackage

// File: rtl/rising_edge_detector.sv
// Single-cycle rising-edge pulse with a configurable history reset value,
// so a level already high at reset release does not count as an edge.
module rising_edge_detector #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic signal_i,
   output logic edge_o
);

   logic signal_q;

   // Previous-cycle copy of the monitored level.
   always_ff @(posedge clk) begin
      if (rst) begin
         signal_q <= RESET_VALUE;
      end else begin
         signal_q <= signal_i;
      end
   end

   assign edge_o = signal_i & ~signal_q;

endmodule

// File: rtl/spi_config_sram_bridge.sv
// Converts SPI write pulses and read levels into single-port SRAM accesses,
// with one-deep pending slots per request type and a sticky overrun flag.
module spi_config_sram_bridge
   import spi_config_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 32'd10,
   parameter int unsigned DATA_WIDTH    = 32'd32,
   parameter int unsigned READ_LATENCY  = 32'd1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable_configuration,
   input  logic                     write_new,
   input  logic                     read_sync,
   input  logic [ADDRESS_WIDTH-1:0] mosi_address,
   input  logic [DATA_WIDTH-1:0]    mosi_data,
   output logic                     sram_chip_select,
   output logic                     sram_write_enable,
   output logic [ADDRESS_WIDTH-1:0] sram_address,
   output logic [DATA_WIDTH-1:0]    sram_write_data,
   input  logic [DATA_WIDTH-1:0]    sram_read_data,
   output logic [DATA_WIDTH-1:0]    miso_data,
   output logic                     miso_data_valid,
   output logic                     overrun
);

   localparam logic [LAT_CNT_WIDTH-1:0] LAT_LOAD = latency_load(READ_LATENCY);

   state_e                   state_q;
   logic                     write_pending_q;
   logic                     read_pending_q;
   logic [LAT_CNT_WIDTH-1:0] count_q;
   logic [DATA_WIDTH-1:0]    miso_data_q;
   logic                     miso_valid_q;
   logic                     overrun_q;
   logic                     read_edge_s;

   rising_edge_detector #(
      .RESET_VALUE (1'b1)
   ) u_read_edge (
      .clk      (clk),
      .rst      (rst),
      .signal_i (read_sync),
      .edge_o   (read_edge_s)
   );

   // Request sequencing, read-latency countdown and MISO result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         write_pending_q <= 1'b0;
         read_pending_q  <= 1'b0;
         count_q         <= {LAT_CNT_WIDTH{1'b0}};
         miso_data_q     <= {DATA_WIDTH{1'b0}};
         miso_valid_q    <= 1'b0;
         overrun_q       <= 1'b0;
      end else if (!enable_configuration) begin
         state_q         <= IDLE;
         write_pending_q <= 1'b0;
         read_pending_q  <= 1'b0;
         count_q         <= {LAT_CNT_WIDTH{1'b0}};
      end else begin
         if ((write_new && write_pending_q) || (read_edge_s && read_pending_q)) begin
            overrun_q <= 1'b1;
         end
         if (read_edge_s) begin
            miso_valid_q <= 1'b0;
         end
         // New requests queue by default; the states below consume them.
         write_pending_q <= write_pending_q | write_new;
         read_pending_q  <= read_pending_q | read_edge_s;
         case (state_q)
            IDLE: begin
               if (write_new || write_pending_q) begin
                  state_q         <= WRITE;
                  write_pending_q <= 1'b0;
               end else if (read_edge_s || read_pending_q) begin
                  state_q        <= READ;
                  read_pending_q <= 1'b0;
               end else begin
                  state_q <= IDLE;
               end
            end
            WRITE: begin
               if (!(write_new || write_pending_q) && (read_edge_s || read_pending_q)) begin
                  state_q        <= READ;
                  read_pending_q <= 1'b0;
               end else begin
                  state_q <= IDLE;
               end
            end
            READ: begin
               count_q <= LAT_LOAD;
               state_q <= READ_WAIT;
            end
            READ_WAIT: begin
               if (count_q == {LAT_CNT_WIDTH{1'b0}}) begin
                  miso_data_q  <= sram_read_data;
                  miso_valid_q <= ~read_edge_s;
                  state_q      <= IDLE;
               end else begin
                  count_q <= count_q - LAT_CNT_WIDTH'(1'b1);
                  state_q <= READ_WAIT;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // SRAM strobes decode straight from state so they drop as soon as state leaves an access.
   always_comb begin
      sram_chip_select  = 1'b0;
      sram_write_enable = 1'b0;
      sram_address      = {ADDRESS_WIDTH{1'b0}};
      sram_write_data   = {DATA_WIDTH{1'b0}};
      case (state_q)
         WRITE: begin
            sram_chip_select  = 1'b1;
            sram_write_enable = 1'b1;
            sram_address      = mosi_address;
            sram_write_data   = mosi_data;
         end
         READ: begin
            sram_chip_select = 1'b1;
            sram_address     = mosi_address;
         end
         default: begin
            sram_chip_select = 1'b0;
         end
      endcase
   end

   assign miso_data       = miso_data_q;
   assign miso_data_valid = miso_valid_q;
   assign overrun         = overrun_q;

endmodule

// File: tb/tb_spi_config_sram_bridge.sv
// Self-checking bench: directed scenarios plus a randomized run compared
// against an operation-duration reference model and a latency-accurate SRAM.
module tb_spi_config_sram_bridge;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          rst, en, wn, rs;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          sram_chip_select, sram_write_enable;
   logic [AW-1:0] sram_address;
   logic [DW-1:0] sram_write_data, sram_read_data, miso_data;
   logic          miso_data_valid, overrun;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   spi_config_sram_bridge #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .READ_LATENCY  (RL)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .enable_configuration (en),
      .write_new            (wn),
      .read_sync            (rs),
      .mosi_address         (addr),
      .mosi_data            (wdata),
      .sram_chip_select     (sram_chip_select),
      .sram_write_enable    (sram_write_enable),
      .sram_address         (sram_address),
      .sram_write_data      (sram_write_data),
      .sram_read_data       (sram_read_data),
      .miso_data            (miso_data),
      .miso_data_valid      (miso_data_valid),
      .overrun              (overrun)
   );

   // SRAM with RL-cycle read latency; a filler word appears when no read was issued.
   logic [DW-1:0] mem [0:1023];
   logic [DW-1:0] pipe [0:RL-1];
   assign sram_read_data = pipe[RL-1];
   always @(posedge clk) begin
      if (sram_chip_select && sram_write_enable) mem[sram_address] <= sram_write_data;
      pipe[0] <= (sram_chip_select && !sram_write_enable) ? mem[sram_address] : 32'hBAD0_BAD0;
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
   end

   // Reference model: an access occupies the engine for a fixed number of cycles
   // (write 1, read 1+RL); the strobe is the first of those cycles.
   logic [DW-1:0] ref_mem [0:1023];
   bit            m_rs_prev, m_wp, m_rp, m_valid, m_ovr, m_is_write;
   int            m_remaining, m_len;
   logic [DW-1:0] m_miso, m_rd_expect;
   logic [DW-1:0] sim_data;

   task automatic model_step();
      bit redge;
      if (m_remaining > 0 && m_remaining == m_len) begin
         if (m_is_write) ref_mem[addr] = wdata;
         else m_rd_expect = ref_mem[addr];
      end
      if (rst) begin
         m_rs_prev = 1'b1; m_wp = 1'b0; m_rp = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
         m_miso = '0; m_remaining = 0; m_len = 1; m_is_write = 1'b0;
         return;
      end
      redge = rs && !m_rs_prev;
      m_rs_prev = rs;
      if (!en) begin
         m_remaining = 0; m_wp = 1'b0; m_rp = 1'b0;
         return;
      end
      if ((wn && m_wp) || (redge && m_rp)) m_ovr = 1'b1;
      if (redge) m_valid = 1'b0;
      if (m_remaining > 0) begin
         m_remaining--;
         if (!m_is_write && m_remaining == 0) begin
            m_miso = m_rd_expect;
            m_valid = !redge;
         end
         m_wp = m_wp | wn;
         m_rp = m_rp | redge;
         if (m_is_write && !m_wp && m_rp) begin
            m_is_write = 1'b0; m_len = 1 + RL; m_remaining = m_len; m_rp = 1'b0;
         end
      end else if (wn || m_wp) begin
         m_is_write = 1'b1; m_len = 1; m_remaining = 1; m_wp = 1'b0; m_rp = m_rp | redge;
      end else if (redge || m_rp) begin
         m_is_write = 1'b0; m_len = 1 + RL; m_remaining = m_len; m_rp = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; wn = 1'b0; rs = 1'b0; addr = '0; wdata = '0;
      tick(); tick();
      rst = 1'b0; #1;
      n_tests++;
      if ({sram_chip_select, sram_write_enable, sram_address, sram_write_data} !== {2'b00, 10'h000, 32'h0}) begin
         n_fail++; $display("FAIL reset_strobes got cs=%b we=%b a=%h d=%h want all 0", sram_chip_select, sram_write_enable, sram_address, sram_write_data);
      end
      n_tests++;
      if ({miso_data, miso_data_valid, overrun} !== {32'h0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL reset_outputs got miso=%h v=%b ovr=%b want 0/0/0", miso_data, miso_data_valid, overrun);
      end
   endtask

   task automatic test_write();
      addr = 10'h005; wdata = 32'hDEADBEEF; wn = 1'b1;
      tick(); wn = 1'b0; #1;
      n_tests++;
      if ({sram_chip_select, sram_write_enable, sram_address, sram_write_data} !== {2'b11, 10'h005, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL write_strobe got cs=%b we=%b a=%h d=%h want 1 1 005 deadbeef", sram_chip_select, sram_write_enable, sram_address, sram_write_data);
      end
      tick(); #1;
      n_tests++;
      if ({sram_chip_select, sram_write_enable, sram_address, sram_write_data} !== {2'b00, 10'h000, 32'h0}) begin
         n_fail++; $display("FAIL write_release got cs=%b we=%b a=%h d=%h want all 0", sram_chip_select, sram_write_enable, sram_address, sram_write_data);
      end
   endtask

   task automatic test_read();
      rs = 1'b1;
      tick(); #1;
      n_tests++;
      if ({sram_chip_select, sram_write_enable, sram_address} !== {2'b10, 10'h005}) begin
         n_fail++; $display("FAIL read_strobe got cs=%b we=%b a=%h want 1 0 005", sram_chip_select, sram_write_enable, sram_address);
      end
      tick(); tick(); #1;
      n_tests++;
      if (miso_data_valid !== 1'b0) begin
         n_fail++; $display("FAIL read_early_valid got %b want 0", miso_data_valid);
      end
      tick(); #1;
      n_tests++;
      if ({miso_data, miso_data_valid} !== {32'hDEADBEEF, 1'b1}) begin
         n_fail++; $display("FAIL read_result got %h v=%b want deadbeef v=1", miso_data, miso_data_valid);
      end
   endtask

   task automatic test_simultaneous();
      rs = 1'b0; tick(); tick();
      sim_data = $urandom;
      addr = 10'h01A; wdata = sim_data; wn = 1'b1; rs = 1'b1;
      tick(); wn = 1'b0; #1;
      n_tests++;
      if ({sram_chip_select, sram_write_enable, sram_address, sram_write_data} !== {2'b11, 10'h01A, sim_data}) begin
         n_fail++; $display("FAIL simul_write got cs=%b we=%b a=%h d=%h want 1 1 01a %h", sram_chip_select, sram_write_enable, sram_address, sram_write_data, sim_data);
      end
      tick(); #1;
      n_tests++;
      if ({sram_chip_select, sram_write_enable, sram_address} !== {2'b10, 10'h01A}) begin
         n_fail++; $display("FAIL simul_read got cs=%b we=%b a=%h want 1 0 01a", sram_chip_select, sram_write_enable, sram_address);
      end
      repeat (RL) tick();
      #1;
      n_tests++;
      if (miso_data_valid !== 1'b0) begin
         n_fail++; $display("FAIL simul_early_valid got %b want 0", miso_data_valid);
      end
      tick(); #1;
      n_tests++;
      if ({miso_data, miso_data_valid, overrun} !== {sim_data, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL simul_result got %h v=%b ovr=%b want %h v=1 ovr=0", miso_data, miso_data_valid, overrun, sim_data);
      end
   endtask

   task automatic test_overrun();
      logic [4:0] got_cs;
      addr = 10'h033; wdata = 32'h0BADF00D; wn = 1'b1;
      tick(); #1; got_cs[0] = sram_chip_select;
      tick(); #1; got_cs[1] = sram_chip_select;
      tick(); #1; got_cs[2] = sram_chip_select;
      wn = 1'b0;
      n_tests++;
      if (overrun !== 1'b1) begin
         n_fail++; $display("FAIL overrun_set got %b want 1", overrun);
      end
      tick(); #1; got_cs[3] = sram_chip_select;
      tick(); #1; got_cs[4] = sram_chip_select;
      n_tests++;
      if (got_cs !== 5'b00101) begin
         n_fail++; $display("FAIL overrun_strobes got cs history %b want 00101", got_cs);
      end
      repeat (3) tick();
      #1;
      n_tests++;
      if (overrun !== 1'b1) begin
         n_fail++; $display("FAIL overrun_sticky got %b want 1", overrun);
      end
   endtask

   task automatic test_disable_mid_read();
      int strobes;
      strobes = 0;
      rs = 1'b0; addr = 10'h033; tick();
      rs = 1'b1; tick();
      tick();
      en = 1'b0; tick();
      wn = 1'b1; tick(); wn = 1'b0;
      repeat (RL + 2) begin
         #1; strobes += int'(sram_chip_select);
         tick();
      end
      #1;
      n_tests++;
      if (strobes !== 0) begin
         n_fail++; $display("FAIL disable_strobes got %0d strobes want 0", strobes);
      end
      n_tests++;
      if ({miso_data, miso_data_valid} !== {sim_data, 1'b0}) begin
         n_fail++; $display("FAIL disable_hold got %h v=%b want %h v=0", miso_data, miso_data_valid, sim_data);
      end
      en = 1'b1; tick();
      addr = 10'h044; wdata = 32'h1234_5678; wn = 1'b1;
      tick(); wn = 1'b0; #1;
      n_tests++;
      if ({sram_chip_select, sram_write_enable, sram_address, sram_write_data} !== {2'b11, 10'h044, 32'h1234_5678}) begin
         n_fail++; $display("FAIL reenable_write got cs=%b we=%b a=%h d=%h want 1 1 044 12345678", sram_chip_select, sram_write_enable, sram_address, sram_write_data);
      end
      tick();
   endtask

   task automatic test_reset_level();
      int strobes;
      strobes = 0;
      rs = 1'b0; tick();
      rs = 1'b1; rst = 1'b1; tick(); tick();
      rst = 1'b0;
      repeat (6) begin
         #1; strobes += int'(sram_chip_select);
         tick();
      end
      #1;
      n_tests++;
      if (strobes !== 0) begin
         n_fail++; $display("FAIL reset_level_strobes got %0d strobes want 0", strobes);
      end
      n_tests++;
      if ({overrun, miso_data_valid, miso_data} !== {1'b0, 1'b0, 32'h0}) begin
         n_fail++; $display("FAIL reset_level_outputs got ovr=%b v=%b miso=%h want 0 0 0", overrun, miso_data_valid, miso_data);
      end
   endtask

   task automatic test_random();
      logic          e_cs, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      for (int cyc = 0; cyc < 800; cyc++) begin
         rst   = ($urandom_range(0, 249) == 0);
         en    = ($urandom_range(0, 19) != 0);
         wn    = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) rs = ~rs;
         addr  = AW'($urandom_range(0, 31));
         wdata = $urandom;
         #1;
         e_cs    = (m_remaining > 0) && (m_remaining == m_len);
         e_we    = e_cs && m_is_write;
         e_addr  = e_cs ? addr : '0;
         e_wdata = e_we ? wdata : '0;
         n_tests++;
         if ({sram_chip_select, sram_write_enable, sram_address, sram_write_data} !== {e_cs, e_we, e_addr, e_wdata}) begin
            n_fail++; $display("FAIL rand_sram cyc %0d got cs=%b we=%b a=%h d=%h want cs=%b we=%b a=%h d=%h", cyc, sram_chip_select, sram_write_enable, sram_address, sram_write_data, e_cs, e_we, e_addr, e_wdata);
         end
         n_tests++;
         if ({miso_data, miso_data_valid, overrun} !== {m_miso, m_valid, m_ovr}) begin
            n_fail++; $display("FAIL rand_miso cyc %0d got %h v=%b ovr=%b want %h v=%b ovr=%b", cyc, miso_data, miso_data_valid, overrun, m_miso, m_valid, m_ovr);
         end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = 32'(i) * 32'h9E37_79B9;
         ref_mem[i] = 32'(i) * 32'h9E37_79B9;
      end
      rst = 1'b1; en = 1'b1; wn = 1'b0; rs = 1'b0; addr = '0; wdata = '0;
      m_remaining = 0; m_len = 1;
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_simultaneous();
      test_overrun();
      test_disable_mid_read();
      test_reset_level();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
